// File: rtl/logic_acc_unit_pkg.sv
// Shared ALU encodings for the bitwise logic/accumulate datapath:
// per-beat function codes, reduction codes and the group state.
package logic_acc_unit_pkg;

    localparam int OP_W  = 3;
    localparam int RED_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [RED_W-1:0] {
        RED_OR      = 2'b00,
        RED_AND     = 2'b01,
        RED_XOR     = 2'b10,
        RED_REPLACE = 2'b11
    } red_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/logic_acc_unit_bitwise_fn.sv
// Combinational two-operand bitwise function; bit i of r depends only on x[i], y[i].
module bitwise_fn
    import logic_acc_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] r
);

    // Select the per-beat function.
    always_comb begin
        r = '0;
        case (op_e'(op))
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOR:  r = ~(x | y);
            OP_NAND: r = ~(x & y);
            OP_XNOR: r = ~(x ^ y);
            OP_ANDN: r = x & ~y;
            OP_PASS: r = x;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/logic_acc_unit.sv
// Registered bitwise logic unit that folds multi-beat groups into one result
// word, with a valid/ready input stream and a one-entry registered output.
module logic_acc_unit
    import logic_acc_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [OP_W-1:0]   op,
    input  logic [RED_W-1:0]  red,
    input  logic              last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  f,
    output logic              zero,
    output logic [CNTW-1:0]   beats
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_e            state_r,     state_nxt_s;
    logic [WIDTH-1:0]  acc_r,       acc_nxt_s;
    logic [CNTW-1:0]   cnt_r,       cnt_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic [WIDTH-1:0]  f_r,         f_nxt_s;
    logic              zero_r,      zero_nxt_s;
    logic [CNTW-1:0]   beats_r,     beats_nxt_s;
    logic [WIDTH-1:0]  beat_res_s;
    logic [WIDTH-1:0]  comb_res_s;
    logic [CNTW-1:0]   cnt_inc_s;
    logic              fire_s;

    bitwise_fn #(.WIDTH(WIDTH)) u_fn (
        .x  (x),
        .y  (y),
        .op (op),
        .r  (beat_res_s)
    );

    // A non-last beat also stalls behind an unconsumed result.
    assign in_ready = !out_valid_r || out_ready;
    assign fire_s   = in_valid && in_ready;

    // Fold the new beat into the open accumulator and advance the saturating count.
    always_comb begin
        comb_res_s = beat_res_s;
        case (red_e'(red))
            RED_OR:      comb_res_s = acc_r | beat_res_s;
            RED_AND:     comb_res_s = acc_r & beat_res_s;
            RED_XOR:     comb_res_s = acc_r ^ beat_res_s;
            RED_REPLACE: comb_res_s = beat_res_s;
            default:     comb_res_s = beat_res_s;
        endcase
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = CNT_MAX;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state, accumulator and output-register update.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        cnt_nxt_s       = cnt_r;
        out_valid_nxt_s = out_valid_r && !out_ready;
        f_nxt_s         = f_r;
        zero_nxt_s      = zero_r;
        beats_nxt_s     = beats_r;
        if (fire_s) begin
            case (state_r)
                IDLE: begin
                    if (last) begin
                        f_nxt_s         = beat_res_s;
                        zero_nxt_s      = (beat_res_s == '0);
                        beats_nxt_s     = CNT_ONE;
                        out_valid_nxt_s = 1'b1;
                    end else begin
                        acc_nxt_s   = beat_res_s;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = ACCUM;
                    end
                end
                ACCUM: begin
                    if (last) begin
                        f_nxt_s         = comb_res_s;
                        zero_nxt_s      = (comb_res_s == '0);
                        beats_nxt_s     = cnt_inc_s;
                        out_valid_nxt_s = 1'b1;
                        state_nxt_s     = IDLE;
                    end else begin
                        acc_nxt_s = comb_res_s;
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, accumulator, count and output register; reset drops any open group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            f_r         <= '0;
            zero_r      <= 1'b1;
            beats_r     <= '0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            f_r         <= f_nxt_s;
            zero_r      <= zero_nxt_s;
            beats_r     <= beats_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign f         = f_r;
    assign zero      = zero_r;
    assign beats     = beats_r;

endmodule

// File: tb/tb_logic_acc_unit.sv
// Directed self-checking bench for logic_acc_unit; a second instance with a
// 2-bit beat counter shares the stimulus to exercise count saturation.
module tb_logic_acc_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] x, y;
    logic [2:0]  op;
    logic [1:0]  red;
    logic        last;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] f, f2;
    logic        zero, zero2;
    logic [7:0]  beats;
    logic [1:0]  beats2;

    int n_cmp;
    int n_err;

    logic_acc_unit #(.WIDTH(32), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .red(red), .last(last),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .zero(zero), .beats(beats)
    );

    logic_acc_unit #(.WIDTH(32), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .x(x), .y(y), .op(op), .red(red), .last(last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .f(f2), .zero(zero2), .beats(beats2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One accepted beat: present, take the edge, sample 1 time unit later.
    task automatic beat(input logic [31:0] bx, input logic [31:0] by,
                        input logic [2:0] bop, input logic [1:0] bred, input logic blast);
        x = bx; y = by; op = bop; red = bred; last = blast; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = 32'h0; y = 32'h0; op = 3'd0; red = 2'd0; last = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_f",         f,                  32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd1);
        chk("rst_beats",     {24'd0, beats},     32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Single-beat groups, back to back.
        beat(32'h9, 32'h3, 3'b001, 2'b00, 1'b1);
        chk("or_valid", {31'd0, out_valid}, 32'd1);
        chk("or_f",     f,                  32'h0000_000B);
        chk("or_beats", {24'd0, beats},     32'd1);
        beat(32'h9, 32'h3, 3'b000, 2'b00, 1'b1);
        chk("and_f",    f,                  32'h0000_0001);
        chk("and_valid", {31'd0, out_valid}, 32'd1);
        beat(32'h9, 32'h3, 3'b010, 2'b00, 1'b1);
        chk("xor_f",    f,                  32'h0000_000A);
        beat(32'h9, 32'h3, 3'b011, 2'b00, 1'b1);
        chk("nor_f",    f,                  32'hFFFF_FFF4);
        chk("nor_zero", {31'd0, zero},      32'd0);
        beat(32'h9, 32'h3, 3'b110, 2'b00, 1'b1);
        chk("andn_f",   f,                  32'h0000_0008);
        chk("andn_beats", {24'd0, beats},   32'd1);
        idle_cycle();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // PASS/OR group of three.
        beat(32'h1,   32'h0, 3'b111, 2'b00, 1'b0);
        chk("grp_b1_valid", {31'd0, out_valid}, 32'd0);
        beat(32'h10,  32'h0, 3'b111, 2'b00, 1'b0);
        chk("grp_b2_valid", {31'd0, out_valid}, 32'd0);
        beat(32'h100, 32'h0, 3'b111, 2'b00, 1'b1);
        chk("grp_valid", {31'd0, out_valid}, 32'd1);
        chk("grp_f",     f,                  32'h0000_0111);
        chk("grp_beats", {24'd0, beats},     32'd3);

        // XOR fold to zero; first beat's red is ignored.
        beat(32'hF0F0, 32'h0F0F, 3'b010, 2'b01, 1'b0);
        beat(32'hFFFF, 32'h0000, 3'b010, 2'b10, 1'b1);
        chk("xfold_f",     f,              32'h0);
        chk("xfold_zero",  {31'd0, zero},  32'd1);
        chk("xfold_beats", {24'd0, beats}, 32'd2);

        // Backpressure: offered last beat must not be taken while stalled.
        out_ready = 1'b0;
        x = 32'h5; y = 32'h0; op = 3'b111; red = 2'b00; last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready},  32'd0);
            chk("bp_valid",    {31'd0, out_valid}, 32'd1);
            chk("bp_f",        f,                  32'h0);
            chk("bp_beats",    {24'd0, beats},     32'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_new_f",     f,                  32'h5);
        chk("bp_new_beats", {24'd0, beats},     32'd1);
        chk("bp_new_zero",  {31'd0, zero},      32'd0);
        idle_cycle();
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

        // Six-beat group: 2-bit counter saturates at 3, 8-bit counter reads 6.
        for (int i = 1; i <= 6; i++) begin
            beat(32'(i), 32'h0, 3'b111, 2'b00, (i == 6) ? 1'b1 : 1'b0);
        end
        chk("sat_f",       f,               32'h7);
        chk("sat_beats8",  {24'd0, beats},  32'd6);
        chk("sat_beats2",  {30'd0, beats2}, 32'd3);
        chk("sat_f2",      f2,              32'h7);

        // Reset in the middle of an open group.
        beat(32'hF0, 32'h0, 3'b111, 2'b00, 1'b0);
        beat(32'hF0, 32'h0, 3'b111, 2'b00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_f",     f,                  32'h0);
        chk("mid_rst_zero",  {31'd0, zero},      32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        beat(32'h5, 32'h0, 3'b001, 2'b00, 1'b1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_f",     f,                  32'h5);
        chk("post_rst_beats", {24'd0, beats},     32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
